// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared encodings and types for the instruction-fetch stage.
// Holds next-PC select codes, the default NOP encoding, FSM state codes and
// the packed IF/ID payload type used between fetch_unit and its IF/ID register.
package fetch_unit_pkg;

  // IF_branch_select encodings; any value with bit 2 set is reserved and
  // behaves as sequential.
  localparam logic [2:0] SEL_SEQ = 3'b000;
  localparam logic [2:0] SEL_BEQ = 3'b001;
  localparam logic [2:0] SEL_BL  = 3'b010;
  localparam logic [2:0] SEL_BR  = 3'b011;

  localparam logic [15:0] NOP_ENC = 16'h0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'b00,  // ready to issue a request at pc
    S_WAIT = 2'b01,  // live request outstanding
    S_DROP = 2'b10,  // killed request outstanding, response will be discarded
    S_HOLD = 2'b11   // response captured in skid buffer while ID stalls
  } state_e;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } fetch_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// fetch_unit_if_id_reg: IF/ID pipeline register, priority flush > stall > load > bubble.
// Latency: 1 cycle from load_vld_i to valid_o. Backpressure: stall_i freezes contents.
// Ports: flush_i/stall_i controls, load_vld_i + load_dat_i new fetch, instr_o/pc_o/valid_o to ID.
module fetch_unit_if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] NOP_INSTR = NOP_ENC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        load_vld_i,
  input  fetch_t      load_dat_i,
  output logic [15:0] instr_o,
  output logic [15:0] pc_o,
  output logic        valid_o
);

  fetch_t dat_q, dat_d;
  logic   vld_q, vld_d;

  // Bubbles keep the last pc; only instr and valid are meaningful downstream.
  always_comb begin
    dat_d = dat_q;
    vld_d = vld_q;
    if (flush_i) begin
      dat_d.instr = NOP_INSTR;
      vld_d       = 1'b0;
    end else if (stall_i) begin
      dat_d = dat_q;
      vld_d = vld_q;
    end else if (load_vld_i) begin
      dat_d = load_dat_i;
      vld_d = 1'b1;
    end else begin
      dat_d.instr = NOP_INSTR;
      vld_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_q <= '{instr: NOP_INSTR, pc: 16'h0000};
      vld_q <= 1'b0;
    end else begin
      dat_q <= dat_d;
      vld_q <= vld_d;
    end
  end

  assign instr_o = dat_q.instr;
  assign pc_o    = dat_q.pc;
  assign valid_o = vld_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage; owns pc, issues single-outstanding imem requests, squashes on redirect.
// Latency: >=2 cycles pc->IF/ID (request + response); 1 instr / 2 cycles with 1-cycle imem.
// Backpressure: stall holds IF/ID, a response arriving under stall parks in a 1-entry skid.
// Ports: IF_branch_select + *_target redirect, stall/IF_ID_sync_nop from ID, imem_req/addr/
// rvalid/rdata memory side, IF_ID_instr/pc/valid to ID.
// Optional FETCH_PERF_CNT_EN adds saturating redirect_cnt and drop_cnt outputs.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = NOP_ENC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IF_ID_sync_nop,
  input  logic [2:0]  IF_branch_select,
  input  logic [15:0] beq_target,
  input  logic [15:0] bl_target,
  input  logic [15:0] br_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic [15:0] IF_ID_instr,
  output logic [15:0] IF_ID_pc,
  output logic        IF_ID_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] redirect_cnt,
  output logic [15:0] drop_cnt
`endif
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] skid_q, skid_d;
  logic        skid_vld_q, skid_vld_d;

  logic        redirect;
  logic [15:0] target;
  logic        req_c;
  logic        ld_vld;
  fetch_t      ld_dat;

  always_comb begin
    redirect = 1'b0;
    target   = pc_q;
    case (IF_branch_select)
      SEL_SEQ: ;
      SEL_BEQ: begin redirect = 1'b1; target = beq_target; end
      SEL_BL:  begin redirect = 1'b1; target = bl_target;  end
      SEL_BR:  begin redirect = 1'b1; target = br_target;  end
      default: ;
    endcase
  end

  // pc stays on the instruction being fetched until it is handed to IF/ID,
  // so the load always carries pc_q as its address.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_d       = skid_q;
    skid_vld_d   = skid_vld_q;
    req_c        = 1'b0;
    ld_vld       = 1'b0;
    ld_dat.instr = imem_rdata;
    ld_dat.pc    = pc_q;
    case (state_q)
      S_REQ: begin
        if (redirect) begin
          pc_d = target;
        end else begin
          req_c   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d    = target;
          state_d = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          if (stall) begin
            skid_d     = imem_rdata;
            skid_vld_d = 1'b1;
            state_d    = S_HOLD;
          end else begin
            ld_vld  = 1'b1;
            pc_d    = pc_q + 16'd1;
            state_d = S_REQ;
          end
        end
      end
      S_DROP: begin
        // A response arriving together with a new redirect is the stale one;
        // consuming it here avoids waiting for a response that never comes.
        if (redirect) pc_d = target;
        if (imem_rvalid) state_d = S_REQ;
      end
      S_HOLD: begin
        if (redirect) begin
          skid_vld_d = 1'b0;
          pc_d       = target;
          state_d    = S_REQ;
        end else if (!stall) begin
          ld_vld       = skid_vld_q;
          ld_dat.instr = skid_q;
          skid_vld_d   = 1'b0;
          pc_d         = pc_q + 16'd1;
          state_d      = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      skid_q     <= NOP_INSTR;
      skid_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  // Gated by rst_n so no request strobe is seen while reset is held.
  assign imem_req  = rst_n & req_c;
  assign imem_addr = pc_q;

  fetch_unit_if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (IF_ID_sync_nop),
    .stall_i    (stall),
    .load_vld_i (ld_vld),
    .load_dat_i (ld_dat),
    .instr_o    (IF_ID_instr),
    .pc_o       (IF_ID_pc),
    .valid_o    (IF_ID_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic        drop;
  logic [15:0] redirect_cnt_q, drop_cnt_q;

  assign drop = imem_rvalid &&
                ((state_q == S_WAIT && redirect) || state_q == S_DROP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt_q <= 16'h0000;
      drop_cnt_q     <= 16'h0000;
    end else begin
      if (redirect && redirect_cnt_q != 16'hFFFF) redirect_cnt_q <= redirect_cnt_q + 16'd1;
      if (drop && drop_cnt_q != 16'hFFFF)         drop_cnt_q     <= drop_cnt_q + 16'd1;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign drop_cnt     = drop_cnt_q;
`endif

`ifndef SYNTHESIS
  // Memory must only answer an outstanding request.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(imem_rvalid && (state_q == S_REQ || state_q == S_HOLD)))
        else $error("imem_rvalid with no outstanding request");
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        IF_ID_sync_nop = 1'b0;
  logic [2:0]  IF_branch_select = 3'b000;
  logic [15:0] beq_target = 16'h0000;
  logic [15:0] bl_target = 16'h0000;
  logic [15:0] br_target = 16'h0000;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] IF_ID_instr;
  logic [15:0] IF_ID_pc;
  logic        IF_ID_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] redirect_cnt;
  logic [15:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .IF_ID_sync_nop   (IF_ID_sync_nop),
    .IF_branch_select (IF_branch_select),
    .beq_target       (beq_target),
    .bl_target        (bl_target),
    .br_target        (br_target),
    .stall            (stall),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .IF_ID_instr      (IF_ID_instr),
    .IF_ID_pc         (IF_ID_pc),
    .IF_ID_valid      (IF_ID_valid)
`ifdef FETCH_PERF_CNT_EN
   ,.redirect_cnt     (redirect_cnt),
    .drop_cnt         (drop_cnt)
`endif
  );

  localparam logic [15:0] NOP = 16'h0000;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Memory responder state
  logic        mp_pend = 1'b0;
  logic [15:0] mp_addr = 16'h0000;
  int          mp_cnt  = 0;
  int          mem_fix = -1;   // fixed extra delay, or -1 for random 0..2

  // Reference model: the fetch stream as transactions.
  logic [15:0] m_next_pc = 16'h0000;  // address of the next instruction to fetch
  int          m_inflight = 0;        // 0 none, 1 live fetch, 2 killed fetch
  logic        m_held = 1'b0;         // fetched instruction waiting for ID
  logic [15:0] exp_instr = NOP;
  logic [15:0] exp_pc = 16'h0000;
  logic        exp_vld = 1'b0;
  logic [15:0] m_redir_cnt = 16'h0000;
  logic [15:0] m_drop_cnt = 16'h0000;

  logic [15:0] req_q[$];
  logic [31:0] ld_q[$];

  logic mon_en = 1'b0;
  logic hold_prev;

  // Request monitor: every strobe must match the next predicted address.
  always @(negedge clk) begin
    #2;
    if (mon_en && imem_req) begin
      if (req_q.size() == 0) begin
        n_checks++;
        $display("FAIL req_unexpected: got request at %h, expected none", imem_addr);
      end else begin
        chk("req_addr", {16'h0, imem_addr}, {16'h0, req_q.pop_front()});
      end
    end
  end

  // IF/ID monitor: new loads pop the scoreboard, holds and bubbles use model state.
  always @(posedge clk) begin
    hold_prev = stall && !IF_ID_sync_nop;
    #1;
    if (mon_en) begin
      chk("ifid_valid", {31'h0, IF_ID_valid}, {31'h0, exp_vld});
      if (IF_ID_valid) begin
        if (!hold_prev) begin
          if (ld_q.size() == 0) begin
            n_checks++;
            $display("FAIL ifid_load: got %h@%h, expected no instruction", IF_ID_instr, IF_ID_pc);
          end else begin
            chk("ifid_load", {IF_ID_instr, IF_ID_pc}, ld_q.pop_front());
          end
        end else begin
          chk("ifid_hold", {IF_ID_instr, IF_ID_pc}, {exp_instr, exp_pc});
        end
      end else begin
        chk("ifid_bubble", {16'h0, IF_ID_instr}, {16'h0, NOP});
      end
    end
  end

  // Drive one cycle's inputs (called at a falling edge) and advance the model.
  task automatic drive(input logic [2:0] sel, input logic [15:0] tgt,
                       input logic stl, input logic nop);
    logic        redir;
    logic        req_pred;
    logic        ld;
    logic [15:0] ld_pc;
    if (mp_pend && mp_cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(mp_addr);
      mp_pend     = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 16'($urandom);
      if (mp_pend) mp_cnt--;
    end
    IF_branch_select = sel;
    beq_target = 16'($urandom);
    bl_target  = 16'($urandom);
    br_target  = 16'($urandom);
    case (sel)
      3'b001:  beq_target = tgt;
      3'b010:  bl_target  = tgt;
      3'b011:  br_target  = tgt;
      default: ;
    endcase
    stall = stl;
    IF_ID_sync_nop = nop;
    #1;
    if (imem_req) begin
      mp_pend = 1'b1;
      mp_addr = imem_addr;
      mp_cnt  = (mem_fix >= 0) ? mem_fix : int'($urandom_range(0, 2));
    end

    redir    = (sel == 3'b001 || sel == 3'b010 || sel == 3'b011);
    req_pred = (m_inflight == 0) && !m_held && !redir;
    ld       = 1'b0;
    ld_pc    = 16'h0000;
    if (redir) begin
      if (m_redir_cnt != 16'hFFFF) m_redir_cnt++;
      if (m_inflight != 0 && imem_rvalid && m_drop_cnt != 16'hFFFF) m_drop_cnt++;
      m_inflight = (m_inflight != 0 && !imem_rvalid) ? 2 : 0;
      m_held     = 1'b0;
      m_next_pc  = tgt;
    end else if (req_pred) begin
      req_q.push_back(m_next_pc);
      m_inflight = 1;
    end else if (m_inflight == 1 && imem_rvalid) begin
      m_inflight = 0;
      if (stl) m_held = 1'b1;
      else begin ld = 1'b1; ld_pc = m_next_pc; m_next_pc = m_next_pc + 16'd1; end
    end else if (m_inflight == 2 && imem_rvalid) begin
      m_inflight = 0;
      if (m_drop_cnt != 16'hFFFF) m_drop_cnt++;
    end else if (m_held && !stl) begin
      m_held = 1'b0;
      ld = 1'b1; ld_pc = m_next_pc; m_next_pc = m_next_pc + 16'd1;
    end

    if (nop) begin
      exp_instr = NOP; exp_vld = 1'b0;
    end else if (stl) begin
      // IF/ID keeps its contents
    end else if (ld) begin
      exp_instr = memf(ld_pc); exp_pc = ld_pc; exp_vld = 1'b1;
      ld_q.push_back({memf(ld_pc), ld_pc});
    end else begin
      exp_instr = NOP; exp_vld = 1'b0;
    end
  endtask

  task automatic step(input logic [2:0] sel, input logic [15:0] tgt,
                      input logic stl, input logic nop);
    @(negedge clk);
    drive(sel, tgt, stl, nop);
  endtask

  task automatic rand_step();
    int          r;
    logic [2:0]  sel;
    logic [15:0] tgt;
    r   = int'($urandom_range(0, 11));
    sel = (r < 8) ? 3'b000 : (r == 8) ? 3'b001 : (r == 9) ? 3'b010 :
          (r == 10) ? 3'b011 : 3'(4 + $urandom_range(0, 3));
    tgt = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - $urandom_range(0, 2)) : 16'($urandom);
    step(sel, tgt, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
  endtask

  // Reset asserted at the current time; checks outputs respond asynchronously.
  task automatic do_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("rst_valid", {31'h0, IF_ID_valid}, 32'h0);
    chk("rst_instr", {16'h0, IF_ID_instr}, {16'h0, NOP});
    chk("rst_pc",    {16'h0, IF_ID_pc},    32'h0);
    chk("rst_req",   {31'h0, imem_req},    32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_redirect_cnt", {16'h0, redirect_cnt}, 32'h0);
    chk("rst_drop_cnt",     {16'h0, drop_cnt},     32'h0);
`endif
    imem_rvalid = 1'b0; IF_branch_select = 3'b000; stall = 1'b0; IF_ID_sync_nop = 1'b0;
    mp_pend = 1'b0; mp_cnt = 0;
    m_next_pc = 16'h0000; m_inflight = 0; m_held = 1'b0;
    exp_instr = NOP; exp_pc = 16'h0000; exp_vld = 1'b0;
    m_redir_cnt = 16'h0000; m_drop_cnt = 16'h0000;
    req_q.delete(); ld_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    drive(3'b000, 16'h0000, 1'b0, 1'b0);
  endtask

  function automatic logic reached(input int kind);
    case (kind)
      0:       return m_inflight == 1 && mp_pend && mp_cnt == 0;
      1:       return m_inflight == 1 && mp_pend && mp_cnt > 0;
      2:       return m_inflight == 0 && !m_held;
      default: return exp_vld && m_inflight == 0 && !m_held;
    endcase
  endfunction

  task automatic reach(input int kind);
    for (int i = 0; i < 60; i++) begin
      if (reached(kind)) break;
      step(3'b000, 16'h0000, 1'b0, 1'b0);
    end
    if (!reached(kind)) begin
      n_checks++;
      $display("FAIL reach_%0d: got condition false after 60 cycles, expected true", kind);
    end
  endtask

  initial begin
    #2;
    do_reset();

    // Sequential fetch with a 1-cycle memory.
    mem_fix = 0;
    repeat (8) step(3'b000, 16'h0000, 1'b0, 1'b0);

    // Redirect to bl target while waiting, with a simultaneous flush.
    mem_fix = 2;
    reach(1);
    step(3'b010, 16'h0040, 1'b0, 1'b1);
    repeat (8) step(3'b000, 16'h0000, 1'b0, 1'b0);

    // Response under a 3-cycle stall, then release.
    mem_fix = 1;
    reach(0);
    repeat (3) step(3'b000, 16'h0000, 1'b1, 1'b0);
    repeat (6) step(3'b000, 16'h0000, 1'b0, 1'b0);

    // Redirect while the skid buffer is occupied.
    reach(0);
    step(3'b000, 16'h0000, 1'b1, 1'b0);
    step(3'b011, 16'h1234, 1'b1, 1'b0);
    repeat (8) step(3'b000, 16'h0000, 1'b0, 1'b0);

    // pc wrap from 16'hFFFF.
    mem_fix = 0;
    reach(2);
    step(3'b001, 16'hFFFF, 1'b0, 1'b0);
    repeat (8) step(3'b000, 16'h0000, 1'b0, 1'b0);

    // Reset while a valid instruction sits in IF/ID and a fetch is outstanding.
    mem_fix = 1;
    reach(3);
    step(3'b000, 16'h0000, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    do_reset();
    repeat (8) step(3'b000, 16'h0000, 1'b0, 1'b0);

    // Randomized traffic.
    mem_fix = -1;
    repeat (3000) rand_step();

    // Drain and final bookkeeping.
    repeat (12) step(3'b000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    #3;
    chk("req_q_empty", req_q.size(), 0);
    chk("ld_q_empty",  ld_q.size(),  0);
`ifdef FETCH_PERF_CNT_EN
    chk("redirect_cnt", {16'h0, redirect_cnt}, {16'h0, m_redir_cnt});
    chk("drop_cnt",     {16'h0, drop_cnt},     {16'h0, m_drop_cnt});
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
